// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the 16x oversampled UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } uart_state_t;

  localparam int OVS        = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_W     = 8;

  // True when data plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ~(^d ^ p);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO; pointers carry one extra bit to tell full from empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic                          drop,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_pop;
  logic             do_push;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Head is forced to zero while empty so the output never shows stale storage.
  always_comb begin
    pop_data = '0;
    if (!empty) pop_data = mem[rd_ptr_reg[AW-1:0]];
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 16x oversampled UART receiver (8N1; 8E1 with parity_err when UART_RX_PARITY_EN is defined)
// feeding a small receive FIFO with valid/ready output and error status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVS_DIV    = 260,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ser_rx,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        clr_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
`ifdef UART_RX_PARITY_EN
  , output logic                      parity_err
`endif
);

  localparam logic [15:0] DIV_RELOAD  = 16'(OVS_DIV - 1);
  localparam logic [3:0]  MID_CNT     = 4'(MID_SAMPLE);
  localparam logic [3:0]  LAST_SAMPLE = 4'(OVS - 1);

  uart_state_t       state_reg;
  logic              sync1_reg;
  logic              sync2_reg;
  logic              rx_s;
  logic [15:0]       div_reg;
  logic [3:0]        s_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              push_reg;
  logic              frame_err_reg;
  logic              overrun_reg;
  logic              tick;
  logic              mid;
  logic              bit_end;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_drop;
`ifdef UART_RX_PARITY_EN
  logic              parity_reg;
  logic              parity_err_reg;
  assign parity_err = parity_err_reg;
`endif

  assign rx_s    = sync2_reg;
  assign tick    = (div_reg == '0);
  assign mid     = tick && (s_cnt_reg == MID_CNT);
  assign bit_end = tick && (s_cnt_reg == LAST_SAMPLE);

  assign busy      = (state_reg != IDLE);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign rx_valid  = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= ser_rx;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      div_reg       <= DIV_RELOAD;
      s_cnt_reg     <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_reg     <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      // Reloading on the start edge phase-aligns every sample to that edge.
      if ((state_reg == IDLE && !rx_s) || tick) div_reg <= DIV_RELOAD;
      else                                      div_reg <= div_reg - 16'd1;
      if (tick) s_cnt_reg <= s_cnt_reg + 4'd1;

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START;
            s_cnt_reg <= '0;
          end
        end
        START: begin
          if (mid && rx_s) begin
            state_reg <= IDLE;
          end else if (bit_end) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
          end
        end
        DATA: begin
          if (mid) shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
          if (bit_end) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
`else
            if (bit_cnt_reg == 3'd7) state_reg <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid) parity_reg <= rx_s;
          if (bit_end) state_reg <= STOP;
        end
`endif
        STOP: begin
          // Leave at mid-bit so a back-to-back start bit is not missed.
          if (mid) begin
            if (rx_s) begin
              state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (even_parity_ok(shift_reg, parity_reg)) begin
                push_reg <= 1'b1;
              end else begin
                frame_err_reg  <= 1'b1;
                parity_err_reg <= 1'b1;
              end
`else
              push_reg <= 1'b1;
`endif
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= BRK;
            end
          end
        end
        BRK: begin
          if (rx_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A drop sets the flag even if clr_err is asserted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overrun_reg <= 1'b0;
    else if (fifo_drop) overrun_reg <= 1'b1;
    else if (clr_err)   overrun_reg <= 1'b0;
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_reg),
    .push_data (shift_reg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at OVS_DIV = 4 (one bit = 64 clocks).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_rx;
  logic       rx_ready;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int tests  = 0;
  int errs   = 0;
  int fe_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  uart_rx_ctrl #(.OVS_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_rx     (ser_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a level for n clocks; returns 1 time unit after a rising edge.
  task automatic hold(input logic b, input int n);
    ser_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start + data, then the stop level; returns just after the stop mid-sample edge.
  task automatic send_head(input logic [7:0] d, input logic stop);
    hold(1'b0, 64);
    for (int i = 0; i < 8; i++) hold(d[i], 64);
    hold(stop, 35);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, 1'b1);
    hold(1'b1, 29);
    $display("[TB] frame %02h sent, fifo_count=%0d overrun=%0b", d, fifo_count, overrun);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; ser_rx = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_fifo_count", fifo_count, 3'd0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // Basic receive with exact push latency
    send_head(8'h3D, 1'b1);
    check("basic_valid_before", rx_valid, 1'b0);
    hold(1'b1, 1);
    check("basic_valid", rx_valid, 1'b1);
    check("basic_data", rx_data, 8'h3D);
    check("basic_count", fifo_count, 3'd1);
    hold(1'b1, 28);
    $display("[TB] frame 3d received data=%02h", rx_data);
    pop_one();
    check("basic_pop_count", fifo_count, 3'd0);
    check("basic_pop_valid", rx_valid, 1'b0);

    // Glitch rejection: 3-tick low pulse
    hold(1'b0, 12);
    check("glitch_busy_high", busy, 1'b1);
    hold(1'b1, 40);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_push", fifo_count, 3'd0);
    check("glitch_no_ferr", fe_cnt, 0);
    $display("[TB] glitch pulse rejected");

    // Framing error: stop held low for two bit times
    send_head(8'hA5, 1'b0);
    check("ferr_pulse", frame_err, 1'b1);
    hold(1'b0, 1);
    check("ferr_pulse_end", frame_err, 1'b0);
    hold(1'b0, 92);
    check("ferr_busy_brk", busy, 1'b1);
    check("ferr_fifo_empty", fifo_count, 3'd0);
    hold(1'b1, 4);
    check("ferr_busy_release", busy, 1'b0);
    check("ferr_once", fe_cnt, 1);
    $display("[TB] frame a5 with bad stop, frame_err pulses=%0d", fe_cnt);

    // Overrun: five frames, no pops
    for (int v = 1; v <= 5; v++) send_frame(8'(v));
    check("ovr_count", fifo_count, 3'd4);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_head", rx_data, 8'h01);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("ovr_cleared", overrun, 1'b0);

    // Full FIFO, pop coincides with the push of 0x77
    send_head(8'h77, 1'b1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("full_pop_overrun", overrun, 1'b0);
    check("full_pop_count", fifo_count, 3'd4);
    check("full_pop_head", rx_data, 8'h02);
    hold(1'b1, 28);
    $display("[TB] frame 77 pushed with concurrent pop");
    pop_one();
    check("drain_03", rx_data, 8'h03);
    pop_one();
    check("drain_04", rx_data, 8'h04);
    pop_one();
    check("drain_77", rx_data, 8'h77);
    check("drain_count", fifo_count, 3'd1);

    // Reset mid-frame during data bit 4 of 0xC3
    hold(1'b0, 64);
    hold(1'b1, 64); hold(1'b1, 64); hold(1'b0, 64); hold(1'b0, 64);
    hold(1'b0, 32);
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    ser_rx = 1'b1;
    #1;
    check("midrst_count", fifo_count, 3'd0);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 10);
    check("midrst_idle", busy, 1'b0);
    send_frame(8'hC3);
    check("post_rst_valid", rx_valid, 1'b1);
    check("post_rst_data", rx_data, 8'hC3);
    check("post_rst_count", fifo_count, 3'd1);
    pop_one();
    check("post_rst_empty", fifo_count, 3'd0);
    check("total_ferr", fe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
